nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor for the DSP ALU: diff = a - b - bin.
//  Each cycle one 4-bit slice passes through a single FullSubtractor4 instance, LSB slice first.
//  A borrow flop chains the slices together.
//  Sits between the ALU operand mux (valid/ready upstream) and the ALU result register (valid/ready downstream).
// PARAMETERS
//  WIDTH    16          operand/result width; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4     derived, localparam; number of RUN cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (combinational: state==IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in, applied to slice 0
//  out_valid  out  1      result valid (registered)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH (registered)
//  bout       out  1      borrow-out of the MSB slice (unsigned a < b+bin)
//  ovf        out  1      signed overflow: (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB])
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset:
//   - Asserting rst_n=0 forces state=IDLE, slice idx=0, borrow=0.
//   - Operand registers, diff, bout, ovf and out_valid all go to 0.
//   - in_ready reads 1 and busy reads 0 while in reset.
//  State machine:
//   - IDLE: in_ready=1. On in_valid, latch a, b; borrow<=bin; idx<=0; go to RUN.
//   - RUN: one slice per cycle.
//     - diff[4*idx+:4] <= Diff of FullSubtractor4(a_r slice, b_r slice, borrow).
//     - borrow <= Bout; idx <= idx+1.
//     - On idx==NIBBLES-1: bout <= Bout, ovf <= overflow formula, go to DONE.
//   - DONE: out_valid=1. diff, bout and ovf are held stable. On out_ready, out_valid<=0 and go to IDLE.
//  Latency and throughput:
//   - Acceptance edge at cycle 0; out_valid is high from cycle NIBBLES (4 for WIDTH=16).
//   - Throughput is one op per NIBBLES+2 cycles with out_ready held high.
//  Handshake:
//   - in_valid is ignored outside IDLE; there is no overlap or skid.
//   - A completing out_ready in DONE does not accept new operands that same cycle; IDLE follows.
//   - Upstream a, b and bin may change freely after acceptance; operands are registered.
//   - The diff bits of slices not yet computed are don't-care until out_valid.
//   - The bench checks diff only when out_valid=1.
//  Boundaries:
//   - Borrow ripples through all NIBBLES slices; 0 - 1 yields all-ones with bout=1.
//   - idx width is $clog2(NIBBLES). idx never wraps inside RUN; it is reloaded in IDLE.
//   - Reset during RUN or DONE aborts the op with no partial result; the next accepted op is exact.
//   - out_ready without out_valid has no effect.
// STRUCTURE
//  Shared package alu_pkg:
//   - NIB_W=4.
//   - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
//  Sub-module: exactly one FullSubtractor4 (A, B, Bin, Diff, Bout), fed by an idx-selected slice mux.
//  All other logic lives in this module: FSM, idx counter, operand/borrow/result registers.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x0111, bin=0 -> out_valid 4 cycles after accept; diff=0x1123, bout=0, ovf=0.
//  2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0 (full borrow ripple).
//  3. a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, bout=0, ovf=1.
//     a=0x0003, b=0x0006, bin=1 -> diff=0xFFFC, bout=1, ovf=0.
//  4. Backpressure: hold out_ready=0 for 3 cycles in DONE.
//     -> out_valid stays 1; diff, bout, ovf stable; in_ready=0; in_valid pulses are ignored.
//  5. Reset: assert rst_n=0 after 2 RUN cycles.
//     -> out_valid, diff, bout, ovf, busy = 0 immediately; in_ready=1.
//     -> After release, a=0x00FF, b=0x0F0F -> diff=0xF1F0, bout=1.
//  6. Back-to-back: 8 random ops with out_ready held at 1.
//     -> Each result matches the reference model a-b-bin.
//     -> Each output handshake is followed by one IDLE cycle.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared ALU definitions: slice width, FSM state encoding and the signed-overflow rule.
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ILL  = 2'd3
  } state_t;

  // Overflow of a - b: operands differ in sign and the result sign departs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand (valid/ready) and result (valid/ready) channels of the serial subtractor.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_subtractor_fs4.sv
// 4-bit full subtractor: {Bout, Diff} = A - B - Bin.
module FullSubtractor4
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Bin,
  output logic [NIB_W-1:0] Diff,
  output logic             Bout
);

  // Extra MSB goes high exactly when the difference is negative.
  logic [NIB_W:0] w_res;

  assign w_res = {1'b0, A} - {1'b0, B} - {{NIB_W{1'b0}}, Bin};
  assign Diff  = w_res[NIB_W-1:0];
  assign Bout  = w_res[NIB_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: one 4-bit slice per cycle, LSB first, borrow chained by a flop.
module nibble_serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  nibble_serial_subtractor_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [IDX_W-1:0]               r_idx;
  logic [NIBBLES-1:0][NIB_W-1:0]  r_a;
  logic [NIBBLES-1:0][NIB_W-1:0]  r_b;
  logic [NIBBLES-1:0][NIB_W-1:0]  r_diff;
  logic                           r_borrow;
  logic                           r_bout;
  logic                           r_ovf;
  logic                           r_out_valid;

  logic [NIB_W-1:0]               w_sa;
  logic [NIB_W-1:0]               w_sb;
  logic [NIB_W-1:0]               w_sd;
  logic                           w_sbout;
  logic                           w_last;
  logic                           w_accept;
  logic                           w_out_hs;

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.in_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) begin
        w_out_hs    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single slice datapath shared across all RUN cycles.
  assign w_sa = r_a[r_idx];
  assign w_sb = r_b[r_idx];

  FullSubtractor4 u_fs4 (
    .A    (w_sa),
    .B    (w_sb),
    .Bin  (r_borrow),
    .Diff (w_sd),
    .Bout (w_sbout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_borrow <= bus.bin;
        r_idx    <= '0;
      end
      if (r_state == ST_RUN) begin
        r_diff[r_idx] <= w_sd;
        r_borrow      <= w_sbout;
        // Hold idx on the last slice so it never wraps; IDLE reloads it.
        if (w_last) begin
          r_bout      <= w_sbout;
          r_ovf       <= sub_ovf(r_a[NIBBLES-1][NIB_W-1], r_b[NIBBLES-1][NIB_W-1], w_sd[NIB_W-1]);
          r_out_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_out_hs) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: directed spec cases plus random ops vs an arithmetic model.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hs_pend = 1'b0;
  exp_t q[$];
  int   acc_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus();

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d;
    e.bout = bo;
    e.ovf  = ov;
    return e;
  endfunction

  // Reference: plain unsigned and signed integer arithmetic on a - b - bin.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t         e;
    logic [W:0]   u;
    longint       sr;
    u  = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    e.diff = u[W-1:0];
    e.bout = u[W];
    e.ovf  = (sr > longint'(2**(W-1) - 1)) || (sr < -longint'(2**(W-1)));
    return e;
  endfunction

  // Monitor: pops on every output handshake and checks the following cycle is IDLE.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_pend <= 1'b0;
    end else begin
      if (hs_pend) chk("idle_after_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          chk("diff", bus.diff, q[0].diff);
          chk("bout", bus.bout, q[0].bout);
          chk("ovf",  bus.ovf,  q[0].ovf);
          void'(q.pop_front());
        end
        hs_pend <= 1'b1;
      end else begin
        hs_pend <= 1'b0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
    bit done = 1'b0;
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready && rst_n) begin
        acc_cyc.push_back(cyc);
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) fail_now("accept_timeout");
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic wait_ov(input int max);
    bit seen = 1'b0;
    for (int t = 0; t < max && !seen; t++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    if (!seen) fail_now("out_valid_timeout");
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_diff",      bus.diff, 0);
    chk("rst_bout_ovf",  {bus.bout, bus.ovf}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic op and latency: out_valid rises 4 edges after acceptance.
    issue(16'h1234, 16'h0111, 1'b0, mk(16'h1123, 1'b0, 1'b0));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("latency_out_valid", bus.out_valid, (k == 4) ? 1 : 0);
    end

    issue(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
    issue(16'h8000, 16'h0000, 1'b1, mk(16'h7FFF, 1'b0, 1'b1));
    drain();

    // Backpressure in DONE with ignored in_valid pulses.
    bus.out_ready = 1'b0;
    issue(16'h0003, 16'h0006, 1'b1, mk(16'hFFFC, 1'b1, 1'b0));
    wait_ov(20);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.in_valid = (k != 1);
      bus.a = W'($urandom); bus.b = W'($urandom);
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready",  bus.in_ready, 0);
      chk("bp_diff",      bus.diff, 16'hFFFC);
      chk("bp_bout_ovf",  {bus.bout, bus.ovf}, 2'b10);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset two RUN cycles into an op: everything clears at once.
    ra = W'($urandom); rb = W'($urandom);
    issue(ra, rb, 1'b0, model(ra, rb, 1'b0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_diff",      bus.diff, 0);
    chk("mid_rst_bout_ovf",  {bus.bout, bus.ovf}, 0);
    chk("mid_rst_busy",      bus.busy, 0);
    chk("mid_rst_in_ready",  bus.in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(16'h00FF, 16'h0F0F, 1'b0, mk(16'hF1F0, 1'b1, 1'b0));
    drain();

    // Back-to-back random ops: one accept every NIBBLES+2 cycles.
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      issue(ra, rb, rbin, model(ra, rb, rbin));
    end
    drain();
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("throughput", acc_cyc[i] - acc_cyc[i-1], 6);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
